// File: rtl/prio_queue.sv
// Min-priority queue built as a sorted register array: slot 0 always holds the minimum.
// Each edge can remove the head and/or insert one key at its sorted position.
module prio_queue #(
    parameter int DWIDTH = 16,
    parameter int HDEPTH = 5
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              enq,
    input  logic              deq,
    input  logic [DWIDTH-1:0] inp_data,
    output logic [DWIDTH-1:0] out_data,
    output logic [HDEPTH-1:0] count
);
    localparam int CAP = 2**HDEPTH - 1;

    logic [DWIDTH-1:0] slot_q [CAP];
    logic [DWIDTH-1:0] slot_d [CAP];
    logic [DWIDTH-1:0] base   [CAP];
    logic [HDEPTH-1:0] count_q;
    logic [HDEPTH-1:0] count_d;
    logic [HDEPTH-1:0] base_cnt;
    logic [CAP-1:0]    gt;
    logic              full;
    logic              do_deq;
    logic              do_ins;

    assign full   = (count_q == HDEPTH'(CAP));
    assign do_deq = deq && (count_q != '0);
    // A full queue still accepts an insert when the head leaves in the same cycle.
    assign do_ins = enq && (!full || do_deq);

    assign base_cnt = count_q - HDEPTH'(do_deq);
    assign count_d  = count_q + HDEPTH'(do_ins) - HDEPTH'(do_deq);

    genvar gi;
    generate
        for (gi = 0; gi < CAP; gi++) begin : g_slot
            // Array after an optional dequeue; the vacated top slot becomes 0.
            if (gi == CAP - 1) begin : g_top
                assign base[gi] = do_deq ? '0 : slot_q[gi];
            end else begin : g_mid
                assign base[gi] = do_deq ? slot_q[gi+1] : slot_q[gi];
            end

            // Unused slots count as larger than any key so the insert lands at the tail.
            assign gt[gi] = (HDEPTH'(gi) >= base_cnt) || (base[gi] > inp_data);

            if (gi == 0) begin : g_head
                assign slot_d[gi] = (do_ins && gt[gi]) ? inp_data : base[gi];
            end else begin : g_body
                assign slot_d[gi] = !(do_ins && gt[gi]) ? base[gi] :
                                    (gt[gi-1] ? base[gi-1] : inp_data);
            end

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_data = slot_q[0];
    assign count    = count_q;
endmodule

// File: tb/tb_prio_queue.sv
// Bench for prio_queue: directed vector table, full/empty and async-reset sequences,
// then random traffic against a queue-based reference model.
module tb_prio_queue;
    localparam int DW  = 16;
    localparam int HD  = 5;
    localparam int CAP = 31;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          enq = 1'b0;
    logic          deq = 1'b0;
    logic [DW-1:0] inp_data = '0;
    logic [DW-1:0] out_data;
    logic [HD-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    prio_queue #(.DWIDTH(DW), .HDEPTH(HD)) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .enq      (enq),
        .deq      (deq),
        .inp_data (inp_data),
        .out_data (out_data),
        .count    (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic       de;
        int         d;
        int         exp_out;  // head seen while this row is driven (dequeued value on deq rows)
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic drive(input logic en, input logic de, input int d);
        enq = en;
        deq = de;
        inp_data = DW'(d);
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input logic en, input logic de, input int d,
                                input int eo, input int ec);
        vec_t v;
        v.en = en; v.de = de; v.d = d; v.exp_out = eo; v.exp_cnt = ec;
        return v;
    endfunction

    int model[$];

    function automatic int model_min();
        int m;
        m = model[0];
        foreach (model[k]) if (model[k] < m) m = model[k];
        return m;
    endfunction

    initial begin
        int keys[CAP];
        int prev;
        int tmp;
        int j;
        int pct;

        // Sequence 1
        vecs.push_back(mk(1, 0, 72, 0, 0));
        vecs.push_back(mk(1, 0, 44, 72, 1));
        vecs.push_back(mk(1, 0, 85, 44, 2));
        vecs.push_back(mk(0, 1, 0, 44, 3));
        vecs.push_back(mk(0, 1, 0, 72, 2));
        vecs.push_back(mk(1, 0, 43, 85, 1));
        vecs.push_back(mk(1, 0, 71, 43, 2));
        vecs.push_back(mk(1, 0, 15, 43, 3));
        vecs.push_back(mk(0, 1, 0, 15, 4));
        vecs.push_back(mk(0, 1, 0, 43, 3));
        vecs.push_back(mk(0, 1, 0, 71, 2));
        vecs.push_back(mk(0, 1, 0, 85, 1));
        // Duplicates
        vecs.push_back(mk(1, 0, 93, 0, 0));
        vecs.push_back(mk(1, 0, 20, 93, 1));
        vecs.push_back(mk(1, 0, 23, 20, 2));
        vecs.push_back(mk(1, 0, 23, 20, 3));
        vecs.push_back(mk(0, 1, 0, 20, 4));
        vecs.push_back(mk(0, 1, 0, 23, 3));
        vecs.push_back(mk(0, 1, 0, 23, 2));
        vecs.push_back(mk(0, 1, 0, 93, 1));
        // Replace-min, empty deq, enq&deq on empty
        vecs.push_back(mk(1, 0, 10, 0, 0));
        vecs.push_back(mk(1, 0, 50, 10, 1));
        vecs.push_back(mk(1, 1, 30, 10, 2));
        vecs.push_back(mk(1, 1, 5, 30, 2));
        vecs.push_back(mk(0, 1, 0, 5, 2));
        vecs.push_back(mk(0, 1, 0, 50, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 7, 1));
        vecs.push_back(mk(0, 1, 0, 7, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0));

        #2;
        check("reset_cnt", int'(count), 0);
        check("reset_out", int'(out_data), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            check($sformatf("vec%0d_out", i), int'(out_data), vecs[i].exp_out);
            check($sformatf("vec%0d_cnt", i), int'(count), vecs[i].exp_cnt);
            drive(vecs[i].en, vecs[i].de, vecs[i].d);
        end
        drive(0, 0, 0);

        // Fill with 31 distinct keys in shuffled order
        for (int k = 0; k < CAP; k++) keys[k] = 1000 + 7 * k;
        for (int k = CAP - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = keys[k]; keys[k] = keys[j]; keys[j] = tmp;
        end
        for (int k = 0; k < CAP; k++) drive(1, 0, keys[k]);
        check("full_cnt", int'(count), CAP);
        check("full_min", int'(out_data), 1000);
        drive(1, 0, 1);
        check("drop_cnt", int'(count), CAP);
        check("drop_out", int'(out_data), 1000);
        prev = -1;
        for (int k = 0; k < CAP; k++) begin
            check($sformatf("drain%0d", k), int'(out_data), 1000 + 7 * k);
            drive(0, 1, 0);
        end
        check("drain_cnt", int'(count), 0);
        drive(0, 1, 0);
        check("underflow_cnt", int'(count), 0);
        check("underflow_out", int'(out_data), 0);

        // Asynchronous reset between edges
        drive(1, 0, 300);
        drive(1, 0, 200);
        drive(1, 0, 400);
        drive(0, 0, 0);
        check("pre_rst_cnt", int'(count), 3);
        check("pre_rst_out", int'(out_data), 200);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(count), 0);
        check("async_rst_out", int'(out_data), 0);
        #1 rst_n = 1'b1;
        @(negedge CLK);

        // Random traffic vs reference model (multiset in a queue, min by scan)
        pct = 50;
        for (int c = 0; c < 10000; c++) begin
            logic en, de, ok_ins, do_dq;
            int d, m, idx;
            if (c % 500 == 0) pct = $urandom_range(20, 80);
            check($sformatf("rnd%0d_cnt", c), int'(count), model.size());
            check($sformatf("rnd%0d_out", c), int'(out_data),
                  (model.size() > 0) ? model_min() : 0);
            if (n_bad > 20) break;
            en = ($urandom_range(0, 99) < pct);
            de = ($urandom_range(0, 99) < 100 - pct);
            d  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 65535);
            do_dq  = de && (model.size() > 0);
            ok_ins = en && ((model.size() < CAP) || do_dq);
            if (do_dq) begin
                m = model_min();
                idx = 0;
                foreach (model[k]) if (model[k] == m) idx = k;
                model.delete(idx);
            end
            if (ok_ins) model.push_back(d);
            drive(en, de, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
